// File: rtl/xadc_drp_responder.sv
// Behavioural stand-in for the XADC primitive behind a DRP port.
// Serves DRP reads/writes with a fixed latency over a 128x16 register space and
// runs a round-robin conversion sequencer that loads bench codes into the status
// registers and evaluates the alarm thresholds.
module xadc_drp_responder #(
  parameter int pDRP_LATENCY = 4,
  parameter int pSEQ_PERIOD  = 64
) (
  input  logic        clk_usb,
  input  logic        reset_i,
  input  logic        den_in,
  input  logic        dwe_in,
  input  logic [6:0]  daddr_in,
  input  logic [15:0] di_in,
  output logic        drdy_out,
  output logic [15:0] do_out,
  input  logic [11:0] temp_code_i,
  input  logic [11:0] vccint_code_i,
  input  logic [11:0] vccaux_code_i,
  input  logic [11:0] vbram_code_i,
  output logic        ot_out,
  output logic        user_temp_alarm_out,
  output logic        vccint_alarm_out,
  output logic        vccaux_alarm_out,
  output logic        vbram_alarm_out,
  output logic [4:0]  channel_out,
  output logic        eos_out,
  output logic        drp_error_o
);

  localparam int         CNT_W    = $clog2(pSEQ_PERIOD);
  localparam logic [3:0] LAT_LOAD = 4'(pDRP_LATENCY - 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_PEND = 1'b1} drp_state_t;

  drp_state_t       state_q, state_d;
  logic [3:0]       lat_q, lat_d;
  logic             accept, overlap;
  logic             we_q;
  logic [6:0]       addr_q;
  logic [15:0]      di_q;
  logic [15:0]      regs [128];
  logic [15:0]      do_hold;
  logic [15:0]      rd_val;
  logic             wr_en;
  logic [CNT_W-1:0] seq_cnt;
  logic [1:0]       ch_ptr;
  logic             conv;
  logic [6:0]       conv_addr;
  logic [11:0]      conv_code;
  logic [15:0]      conv_word;

  // Status registers are written only by the sequencer.
  function automatic logic is_status(input logic [6:0] a);
    return (a == 7'h00) || (a == 7'h01) || (a == 7'h02) || (a == 7'h06);
  endfunction

  // Set above the set threshold, clear below the clear threshold, else hold.
  function automatic logic hyst_alarm(input logic prev, input logic [11:0] code,
                                      input logic [11:0] set_thr, input logic [11:0] clr_thr);
    if (code > set_thr) return 1'b1;
    if (code < clr_thr) return 1'b0;
    return prev;
  endfunction

  function automatic logic out_of_range(input logic [11:0] code, input logic [11:0] upper,
                                        input logic [11:0] lower);
    return (code > upper) || (code < lower);
  endfunction

  // DRP transaction state and latency counter.
  always_ff @(posedge clk_usb) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
    end
  end

  // Next state; drdy is high in the final PEND cycle, where a new strobe is also taken.
  always_comb begin
    state_d  = state_q;
    lat_d    = lat_q;
    drdy_out = 1'b0;
    accept   = 1'b0;
    overlap  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (den_in) begin
          accept  = 1'b1;
          state_d = ST_PEND;
          lat_d   = LAT_LOAD;
        end
      end
      ST_PEND: begin
        if (lat_q == 4'd0) begin
          drdy_out = 1'b1;
          if (den_in) begin
            accept = 1'b1;
            lat_d  = LAT_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          lat_d   = lat_q - 4'd1;
          overlap = den_in;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Capture the request fields when a strobe is accepted.
  always_ff @(posedge clk_usb) begin
    if (accept) begin
      we_q   <= dwe_in;
      addr_q <= daddr_in;
      di_q   <= di_in;
    end
  end

  // Free-running conversion timer and channel pointer.
  always_ff @(posedge clk_usb) begin
    if (reset_i) begin
      seq_cnt <= '0;
      ch_ptr  <= '0;
    end else if (conv) begin
      seq_cnt <= '0;
      ch_ptr  <= ch_ptr + 2'd1;
    end else begin
      seq_cnt <= seq_cnt + CNT_W'(1);
    end
  end

  assign conv = (seq_cnt == CNT_W'(pSEQ_PERIOD - 1));

  // Channel being converted this cycle and its incoming code.
  always_comb begin
    conv_addr = 7'h00;
    conv_code = temp_code_i;
    case (ch_ptr)
      2'd1: begin conv_addr = 7'h01; conv_code = vccint_code_i; end
      2'd2: begin conv_addr = 7'h02; conv_code = vccaux_code_i; end
      2'd3: begin conv_addr = 7'h06; conv_code = vbram_code_i;  end
      default: ;
    endcase
  end

  assign conv_word = {conv_code, 4'h0};
  assign eos_out   = conv && (ch_ptr == 2'd3);
  assign wr_en     = drdy_out && we_q && !is_status(addr_q);
  assign rd_val    = (conv && (conv_addr == addr_q)) ? conv_word : regs[addr_q];
  assign do_out    = (drdy_out && !we_q) ? rd_val : do_hold;

  // Register space: reset defaults, DRP write commit, conversion results.
  always_ff @(posedge clk_usb) begin
    if (reset_i) begin
      for (int i = 0; i < 128; i++) regs[i] <= '0;
      regs[7'h50] <= 16'hB5ED;
      regs[7'h51] <= 16'h5999;
      regs[7'h52] <= 16'h9999;
      regs[7'h53] <= 16'hCA30;
      regs[7'h54] <= 16'hA93A;
      regs[7'h55] <= 16'h5111;
      regs[7'h56] <= 16'h91EB;
      regs[7'h57] <= 16'hAE40;
      regs[7'h58] <= 16'h5999;
      regs[7'h5C] <= 16'h5111;
    end else begin
      if (wr_en) regs[addr_q] <= di_q;
      if (conv)  regs[conv_addr] <= conv_word;
    end
  end

  // Read data holds until the next read completes.
  always_ff @(posedge clk_usb) begin
    if (reset_i) do_hold <= '0;
    else if (drdy_out && !we_q) do_hold <= rd_val;
  end

  // Sticky overlap flag.
  always_ff @(posedge clk_usb) begin
    if (reset_i) drp_error_o <= 1'b0;
    else if (overlap) drp_error_o <= 1'b1;
  end

  // Alarm evaluation against thresholds as stored before this conversion edge.
  always_ff @(posedge clk_usb) begin
    if (reset_i) begin
      ot_out              <= 1'b0;
      user_temp_alarm_out <= 1'b0;
      vccint_alarm_out    <= 1'b0;
      vccaux_alarm_out    <= 1'b0;
      vbram_alarm_out     <= 1'b0;
      channel_out         <= '0;
    end else if (conv) begin
      channel_out <= conv_addr[4:0];
      case (ch_ptr)
        2'd0: begin
          user_temp_alarm_out <= hyst_alarm(user_temp_alarm_out, conv_code,
                                            regs[7'h50][15:4], regs[7'h54][15:4]);
          ot_out              <= hyst_alarm(ot_out, conv_code,
                                            regs[7'h53][15:4], regs[7'h57][15:4]);
        end
        2'd1: vccint_alarm_out <= out_of_range(conv_code, regs[7'h51][15:4], regs[7'h55][15:4]);
        2'd2: vccaux_alarm_out <= out_of_range(conv_code, regs[7'h52][15:4], regs[7'h56][15:4]);
        default: vbram_alarm_out <= out_of_range(conv_code, regs[7'h58][15:4], regs[7'h5C][15:4]);
      endcase
    end
  end

endmodule

// File: doc/xadc_drp_responder.md
Name: xadc_drp_responder

Overview:
- Behavioural DRP responder standing in for the XADC primitive on the far side of the DRP port, used when the vendor wizard is not available (Icarus builds).
- Accepts DRP read/write strobes from the register-bridge initiator, returns drdy after a fixed latency, and holds a 128x16 register space.
- Runs a round-robin conversion sequencer that loads bench-driven codes into the status registers, evaluates the alarm thresholds, and drives alarm outputs.

Parameters:
- pDRP_LATENCY, 4, cycles from den_in to drdy_out; legal range 1..15.
- pSEQ_PERIOD, 64, cycles between successive channel conversions; minimum 8.

Ports:
- clk_usb  input  1  sole clock; DRP dclk is the same clock.
- reset_i  input  1  synchronous, active-high reset.
- den_in  input  1  DRP enable; one-cycle strobe starts a transaction.
- dwe_in  input  1  DRP write enable; sampled with den_in.
- daddr_in  input  7  DRP address; sampled with den_in.
- di_in  input  16  DRP write data; sampled with den_in.
- drdy_out  output  1  one-cycle transaction-complete pulse.
- do_out  output  16  read data.
- temp_code_i, vccint_code_i, vccaux_code_i, vbram_code_i  input  12 each  bench analog codes.
- ot_out, user_temp_alarm_out, vccint_alarm_out, vccaux_alarm_out, vbram_alarm_out  output  1 each  alarms.
- channel_out  output  5  last converted channel.
- eos_out  output  1  end-of-sequence pulse.
- drp_error_o  output  1  sticky overlap error.

Behaviour:
- Reset (synchronous, active-high):
  - All outputs go to 0.
  - Any pending transaction is dropped and no drdy_out is issued for it.
  - Sequencer counter and channel pointer go to 0.
  - Status registers go to 0.
  - Thresholds load these values: 0x50=0xB5ED, 0x51=0x5999, 0x52=0x9999, 0x53=0xCA30, 0x54=0xA93A, 0x55=0x5111, 0x56=0x91EB, 0x57=0xAE40, 0x58=0x5999, 0x5C=0x5111.
  - All other registers go to 0.
- DRP transaction states: IDLE and PEND.
  - IDLE: den_in=1 latches dwe/addr/di, loads the latency counter, and moves to PEND.
  - PEND: the counter decrements. At expiry, drdy_out=1 for exactly one cycle, then the block returns to IDLE.
  - Total latency is den_in at cycle 0, drdy_out at cycle pDRP_LATENCY.
  - A new den_in in the same cycle as drdy_out is accepted.
- Read: do_out takes reg[addr] in the drdy cycle and holds it until the next read completes.
- Write: commits in the drdy cycle; do_out is unchanged.
  - Writes to 0x00, 0x01, 0x02 and 0x06 (status, read-only) are ignored but still complete with drdy_out.
- Overlap: den_in while in PEND (other than the completion cycle) is ignored and sets drp_error_o. drp_error_o stays set until reset.
- Sequencer:
  - A free-running counter counts 0..pSEQ_PERIOD-1.
  - At rollover the current channel converts. Order is temp(0x00), vccint(0x01), vccaux(0x02), vbram(0x06), then wraps.
  - A conversion stores {code,4'b0} and sets channel_out to 0, 1, 2 or 6.
  - eos_out pulses for one cycle together with the vbram conversion.
- Alarm evaluation:
  - Alarms are evaluated in the conversion cycle. Compares use the 12 MSBs of the threshold and the threshold value as of the previous cycle.
  - A DRP write to a threshold in the same cycle as a conversion affects only the next conversion.
- Temperature alarms:
  - user_temp_alarm_out sets when code > thr[0x50] and clears when code < thr[0x54]; otherwise it holds.
  - ot_out sets when code > thr[0x53] and clears when code < thr[0x57]; otherwise it holds.
- Supply alarms: each of vccint, vccaux and vbram equals (code > upper) OR (code < lower) from that channel's latest conversion.
- A DRP read of a status register coinciding with its conversion returns the new value.

Test Plan:
- Reset, read 0x50 (den at cycle 0) -> drdy_out at cycle 4, do_out=0xB5ED; no drdy on any other cycle.
- Write 0x1234 to 0x40, then read 0x40 -> do_out=0x1234. Write 0xFFFF to 0x00, then read 0x00 -> last converted temp value, unchanged.
- temp_code_i=0xA00, run 4*pSEQ_PERIOD cycles -> reg 0x00=0xA000, eos_out pulses once per 256 cycles, channel_out cycles through 0,1,2,6.
- temp_code_i=0xB60 -> user_temp_alarm_out=1 and ot_out=0. Then 0xAA0 -> alarm still 1 (hysteresis). Then 0xA90 -> alarm 0. Then 0xCB0 -> ot_out=1.
- vccint_code_i=0x500 -> vccint_alarm_out=1 after the vccint conversion. Then 0x550 -> alarm 0. Write 0x5400 to 0x51 -> next conversion gives alarm 1.
- Second den_in two cycles after the first -> drp_error_o=1, exactly one drdy_out. Assert reset_i during PEND -> no drdy_out, and do_out=0 afterwards.
